delay_meas_multi: RTL
=====================

Name: delay_meas_multi

Overview:
- Multi-channel successor to the single-pair elapsed-time counter in DelayMeasurement.
- Each of N_CH channels measures the clk cycles between a selectable edge on its start input and a selectable edge on its end input.
- Adds input synchronisation, a timeout, and per-channel overrun detection.
- Results from all channels go through a round-robin arbiter into one valid/ready result port, which feeds the UART/readout logic.

Parameters:
- N_CH, 4: number of measurement channels (1..16).
- CNT_W, 16: width of the count and result fields.
- SYNC_STAGES, 2: flip-flop stages on each async start/end input (>=2).
- TIMEOUT, 16'hFFFF: cycle count at which an armed channel aborts; must be <= 2^CNT_W-1 and >= 1.

Ports:
- clk  in  1  system clock; everything rising-edge.
- rst  in  1  asynchronous, active-high reset.
- t_start  in  N_CH  async start strobes, one per channel.
- t_end  in  N_CH  async end strobes, one per channel.
- start_fall  in  N_CH  per channel: 1 = falling edge is the start event, 0 = rising (static config).
- end_fall  in  N_CH  per channel: 1 = falling edge is the end event, 0 = rising (static config).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_ch  out  $clog2(N_CH) (min 1)  channel index of the result.
- res_count  out  CNT_W  measured cycles.
- res_timeout  out  1  result is a timeout, not a real end event.
- drop  out  N_CH  sticky per-channel overrun flags.
- drop_clr  in  1  single-cycle pulse; clears all drop bits.

Behaviour:
- Reset (async assert, sync release):
  - All sync/edge registers go to 0; the edge detector is primed so the first post-reset cycle never creates an edge.
  - All channels go to IDLE; counters are 0.
  - Outputs: res_valid=0, res_ch=0, res_count=0, res_timeout=0, drop=0.
  - A reset mid-measurement discards everything.
- Edge detect:
  - One registered copy after the synchroniser; an event is a 1-cycle pulse on the selected polarity.
  - Start and end share the same synchroniser latency, so it cancels out of the count.
- Channel FSM, IDLE -> ARMED -> DONE -> IDLE:
  - IDLE: on a start event -> ARMED, cnt=0. End events in IDLE are ignored.
  - ARMED: cnt increments each cycle.
    - End event at cnt=k -> DONE with count=k+1, timeout=0. An end one cycle after start gives count=1; count=0 is impossible.
    - If cnt+1 == TIMEOUT and no end event -> DONE with count=TIMEOUT, timeout=1.
    - A further start event while ARMED is ignored (first start wins); it does not set drop.
  - Simultaneous start and end in IDLE: start taken, end ignored.
  - DONE: holds the result until the arbiter grants the channel, then returns to IDLE on the next cycle. A start event in DONE is lost and sets drop[ch].
  - The grant cycle counts as DONE; a start in that same cycle is also dropped.
- Arbiter / output register:
  - Loads when res_valid=0 or (res_valid & res_ready).
  - Picks the first DONE channel searching round-robin from last_grant+1.
  - Latency: end event in cycle E -> channel DONE at E+1 -> res_valid at E+2, if the output register is free.
  - Output fields are stable while res_valid & !res_ready.
  - Back-to-back transfers at 1 per cycle are possible.
- drop bits:
  - Set by overrun, cleared by drop_clr.
  - Set and clear in the same cycle: set wins.
- Arithmetic: unsigned, CNT_W bits. The counter never wraps, because the timeout stops it first.

Decomposition:
- Package delay_meas_pkg holds:
  - the channel state enum (IDLE/ARMED/DONE);
  - the result struct {ch, count, timeout};
  - the CH_W helper function.
- Sub-module delay_meas_chan holds one channel's synchroniser, edge select and FSM. It is instantiated N_CH times in a generate loop.
- The top level holds the round-robin arbiter and the output register.

Test Plan:
- Ch0, rising/rising, end event 37 cycles after the start event, res_ready=1 -> one result {ch=0, count=37, timeout=0}, valid 2 cycles after the synced end event.
- Ch2 start_fall=1, end_fall=1, falling-edge start then falling end 5 cycles later (rising edges in between ignored) -> {ch=2, count=5}.
- Ch1 with TIMEOUT=100, start and no end -> {ch=1, count=100, timeout=1}, after which ch1 accepts a new start.
- All 4 channels finish in the same cycle, res_ready held 0 for 10 cycles then 1 -> first result is held stable, then the results come out in round-robin order 0,1,2,3 on consecutive cycles.
- Ch3 in DONE with res_ready=0, second start pulse -> drop[3]=1 and stays sticky; drop_clr pulse -> drop=0; drop_clr coincident with a new overrun -> drop[3]=1.
- rst asserted while ch0 ARMED and a result pending -> all outputs 0 immediately; after release, an end pulse alone produces no result.

Source files
------------

// File: rtl/delay_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_meas_pkg
//  Description : Shared types and helpers for the multi-channel delay
//                measurement block: channel state encoding, the readout
//                result record and the channel-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_meas_pkg;

    // Channel life cycle: wait for start, count, hold result until granted.
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ARMED = 2'd1,
        CH_DONE  = 2'd2
    } chan_state_e;

    // Widest result record the readout path has to carry (16 channels,
    // 32-bit counts). Narrower instances zero-extend into it.
    localparam int RES_CH_W_MAX  = 4;
    localparam int RES_CNT_W_MAX = 32;

    typedef struct packed {
        logic [RES_CH_W_MAX-1:0]  ch;
        logic [RES_CNT_W_MAX-1:0] count;
        logic                     timeout;
    } res_s;

    // Channel-index width; a single channel still needs one bit.
    function automatic int CH_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_meas_chan.sv
`default_nettype none
// ============================================================================
//  Module      : delay_meas_chan
//  Description : One measurement channel. Synchronises the asynchronous
//                start/end strobes, picks the configured edge polarity and
//                counts clk cycles from the start event to the end event
//                (or to the timeout). Holds the result until granted.
//  Ports       : clk, rst        - clock, async active-high reset
//                t_start, t_end  - async strobes
//                start_fall/end_fall - 1 selects falling edge as the event
//                grant           - arbiter takes the held result this cycle
//                drop_clr        - clears the sticky overrun flag
//                done/count/timeout - held result
//                drop            - sticky overrun flag
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_meas_chan
    import delay_meas_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_start,
    input  logic             t_end,
    input  logic             start_fall,
    input  logic             end_fall,
    input  logic             grant,
    input  logic             drop_clr,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             timeout,
    output logic             drop
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_start_sync;
    logic [SYNC_STAGES-1:0] r_end_sync;
    logic                   r_start_prev;
    logic                   r_end_prev;
    logic                   w_start_lvl;
    logic                   w_end_lvl;
    logic                   w_start_ev;
    logic                   w_end_ev;

    chan_state_e            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   r_timeout;
    logic                   r_drop;
    logic                   w_overrun;

    // Both strobes pass through identical synchroniser + edge stages, so
    // their latency cancels out of the measured interval. Everything resets
    // to 0, which also primes the edge detector: no event can appear in the
    // first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_sync <= '0;
            r_end_sync   <= '0;
            r_start_prev <= 1'b0;
            r_end_prev   <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], t_start};
            r_end_sync   <= {r_end_sync[SYNC_STAGES-2:0], t_end};
            r_start_prev <= w_start_lvl;
            r_end_prev   <= w_end_lvl;
        end
    end

    assign w_start_lvl = r_start_sync[SYNC_STAGES-1];
    assign w_end_lvl   = r_end_sync[SYNC_STAGES-1];

    assign w_start_ev = start_fall ? (~w_start_lvl & r_start_prev)
                                   : (w_start_lvl & ~r_start_prev);
    assign w_end_ev   = end_fall   ? (~w_end_lvl & r_end_prev)
                                   : (w_end_lvl & ~r_end_prev);

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // The counter itself becomes the result: on both the end event and the
    // timeout the stored value is cnt+1 (on timeout that equals TIMEOUT), so
    // no separate result register is needed. An end event in the timeout
    // cycle wins and reports a real measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CH_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                CH_IDLE: begin
                    if (w_start_ev) begin
                        r_state   <= CH_ARMED;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                CH_ARMED: begin
                    r_cnt <= w_cnt_inc;
                    if (w_end_ev) begin
                        r_state   <= CH_DONE;
                        r_timeout <= 1'b0;
                    end else if (w_cnt_inc == C_TIMEOUT) begin
                        r_state   <= CH_DONE;
                        r_timeout <= 1'b1;
                    end
                end
                CH_DONE: begin
                    if (grant) begin
                        r_state <= CH_IDLE;
                    end
                end
                default: begin
                    r_state <= CH_IDLE;
                end
            endcase
        end
    end

    // A start arriving while a result is still held (grant cycle included)
    // is lost; flag it. Setting takes priority over a simultaneous clear.
    assign w_overrun = w_start_ev && (r_state == CH_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (w_overrun) begin
            r_drop <= 1'b1;
        end else if (drop_clr) begin
            r_drop <= 1'b0;
        end
    end

    assign done    = (r_state == CH_DONE);
    assign count   = r_cnt;
    assign timeout = r_timeout;
    assign drop    = r_drop;

endmodule
`default_nettype wire

// File: rtl/delay_meas_multi.sv
`default_nettype none
// ============================================================================
//  Module      : delay_meas_multi
//  Description : N_CH-channel elapsed-time measurement. Each channel counts
//                clk cycles between selectable edges of its start and end
//                strobes; finished results are merged by a round-robin
//                arbiter into a single valid/ready result port.
//  Ports       : clk, rst                  - clock, async active-high reset
//                t_start, t_end [N_CH]     - async strobes per channel
//                start_fall, end_fall      - per-channel edge polarity
//                res_valid/res_ready       - result handshake
//                res_ch, res_count, res_timeout - result fields
//                drop [N_CH], drop_clr     - sticky overrun flags and clear
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_meas_multi
    import delay_meas_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        t_start,
    input  logic [N_CH-1:0]        t_end,
    input  logic [N_CH-1:0]        start_fall,
    input  logic [N_CH-1:0]        end_fall,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CH_W(N_CH)-1:0]  res_ch,
    output logic [CNT_W-1:0]       res_count,
    output logic                   res_timeout,
    output logic [N_CH-1:0]        drop,
    input  logic                   drop_clr
);

    localparam int CHW = CH_W(N_CH);

    logic [N_CH-1:0]  w_done;
    logic [N_CH-1:0]  w_tmo;
    logic [N_CH-1:0]  w_grant;
    logic [CNT_W-1:0] w_cnt [N_CH];

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_chan
            delay_meas_chan #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES),
                .TIMEOUT     (TIMEOUT)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .t_start    (t_start[g]),
                .t_end      (t_end[g]),
                .start_fall (start_fall[g]),
                .end_fall   (end_fall[g]),
                .grant      (w_grant[g]),
                .drop_clr   (drop_clr),
                .done       (w_done[g]),
                .count      (w_cnt[g]),
                .timeout    (w_tmo[g]),
                .drop       (drop[g])
            );
        end
    endgenerate

    logic             r_valid;
    logic [CHW-1:0]   r_ch;
    logic [CNT_W-1:0] r_count;
    logic             r_tmo;
    logic [CHW-1:0]   r_last;
    logic [CHW-1:0]   w_pick;
    logic             w_found;
    logic             w_load;

    // Output register is free when empty or being emptied this cycle, which
    // allows one transfer per cycle.
    assign w_load = ~r_valid | res_ready;

    // Round-robin search starting one past the last granted channel.
    always_comb begin : p_rr_pick
        logic [CHW:0] idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = {1'b0, r_last} + (CHW+1)'(i);
            if (idx >= (CHW+1)'(N_CH)) begin
                idx = idx - (CHW+1)'(N_CH);
            end
            if (!w_found && w_done[idx[CHW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = idx[CHW-1:0];
            end
        end
    end

    // The grant releases the channel; it leaves DONE on the next edge, in
    // step with its result landing in the output register.
    always_comb begin
        w_grant = '0;
        if (w_load && w_found) begin
            w_grant[w_pick] = 1'b1;
        end
    end

    // r_last resets to the highest index so that channel 0 has first
    // priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_count <= '0;
            r_tmo   <= 1'b0;
            r_last  <= CHW'(N_CH - 1);
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) begin
                r_ch    <= w_pick;
                r_count <= w_cnt[w_pick];
                r_tmo   <= w_tmo[w_pick];
                r_last  <= w_pick;
            end
        end
    end

    assign res_valid   = r_valid;
    assign res_ch      = r_ch;
    assign res_count   = r_count;
    assign res_timeout = r_tmo;

endmodule
`default_nettype wire
